ad7606_acq_ctrl: RTL and testbench
==================================

// Module: ad7606_acq_ctrl
// PURPOSE
//  Parametrised AD7606 acquisition controller: paces conversions, waits on BUSY, reads N_CH parallel
//  channels, applies per-channel offset/gain calibration and buffers results as a tagged valid/ready
//  stream. Sits between the ADC pins and downstream processing/EEPROM-calibration logic.
// PARAMETERS
//  N_CH      8     channels read per conversion (1..8)
//  DW        16    ADC sample width (signed two's complement)
//  OW        32    calibrated output width
//  GAIN_FRAC 16    fractional bits of cal gain (unsigned Q(32-GAIN_FRAC).GAIN_FRAC)
//  DEPTH     64    output buffer entries, power of 2, >= N_CH
//  RD_LOW    2     RD low cycles per channel; data sampled on last low cycle
//  RD_HIGH   2     RD high cycles between channels
//  CONV_LOW  2     CONVST low cycles
//  RST_CYC   4     ADC RESET high cycles
//  BUSY_TMO  4096  cycles allowed from CONVST rise to BUSY fall
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          synchronous active-low reset
//  enable      in   1          1 = run; 0 = finish current frame, then IDLE
//  single_shot in   1          1 = one frame per start pulse; 0 = free-running at conv_div
//  start       in   1          trigger pulse (single_shot mode)
//  conv_div    in   16         frame period in clk cycles (free-run); 0 treated as 1
//  os_sel      in   3          oversampling select, registered to ad_os_o while IDLE only
//  busy_i      in   1          ADC BUSY (2-flop synchronised internally)
//  data_i      in   DW         ADC parallel data
//  ad_reset_o  out  1          ADC RESET
//  ad_conv_o   out  1          ADC CONVST (idle high)
//  ad_rd_o     out  1          ADC RD/SCLK, active low
//  ad_cs_o     out  1          ADC CS, active low, low across whole READ
//  ad_os_o     out  3          ADC oversampling pins
//  cal_wr      in   1          write cal_offset/cal_gain for cal_ch
//  cal_ch      in   3          channel index for calibration write
//  cal_offset  in   DW         per-channel offset (signed)
//  cal_gain    in   32         per-channel gain
//  m_data      out  OW         calibrated sample (signed)
//  m_ch        out  3          channel tag of m_data
//  m_last      out  1          1 on last channel of a frame
//  m_valid     out  1          output valid
//  m_ready     in   1          output ready
//  level       out  clog2(DEPTH)+1  buffer occupancy
//  overflow    out  1          sticky: a frame was dropped
//  busy_err    out  1          sticky: BUSY timeout
//  clr_flags   in   1          clears overflow/busy_err
// BEHAVIOUR
//  Reset: ad_reset_o=1, ad_conv_o=1, ad_rd_o=1, ad_cs_o=1, ad_os_o=0, m_valid=0, level=0, flags=0,
//   cal offset=0 / gain=1<<GAIN_FRAC for all channels, FSM=ARST.
//  FSM: ARST (ad_reset_o=1 for RST_CYC cycles) -> IDLE. IDLE -> TRIG when enable.
//   TRIG: free-run fires when period counter reaches conv_div-1; single-shot fires on start.
//   Trigger with free buffer < N_CH: frame dropped, overflow=1, stay TRIG (period counter restarts).
//   CONV: ad_conv_o=0 for CONV_LOW cycles -> WAIT_BUSY: wait synchronised busy rise then fall.
//   No fall within BUSY_TMO cycles: busy_err=1, -> TRIG. Fall -> READ.
//   READ: per channel RD_LOW low + RD_HIGH high; data_i captured on last low cycle; after N_CH
//   channels -> TRIG, or IDLE if enable=0. enable drop never aborts CONV/WAIT_BUSY/READ.
//  Free-run period counter runs independently of frame length; trigger arriving while not in TRIG
//   is lost (no queueing); no overflow set for it.
//  Calibration pipe, 2 stages after capture: s1 = sext(raw) - sext(offset) (DW+1 bits);
//   s2 = (s1 * gain) >>> GAIN_FRAC, saturated to signed OW. Buffer write 2 cycles after capture.
//  cal_wr takes effect for the next captured sample of that channel; cal_ch >= N_CH ignored.
//  Buffer: FWFT, entry = {last, ch, data}. Transfer on m_valid&m_ready. Simultaneous write+read
//   at full/empty handled (level unchanged). Space reserved at trigger, so no intra-frame overflow.
//  clr_flags and a new set event in the same cycle: flag stays 1.
//  Reset mid-frame: all state discarded, ADC re-reset via ARST.
// STRUCTURE
//  Package ad7606_pkg: FSM state enum, MAX_CH=8, gain unity constant, saturate function.
//  One sub-module: ad7606_cal_pipe (2-stage subtract/multiply/saturate with channel+last sideband).
//  Buffer is inline RAM array with wrapping pointers (no vendor IP).
// TESTING
//  1 Reset, enable=1, conv_div=200, BUSY model 40 cycles -> ARST 4 cycles, frames every 200, 8 beats ch0..7, m_last on ch7.
//  2 ch3 offset=100, gain=0x0002_0000, raw=1100 -> m_data=2000; gain=0x0000_8000, raw=-900 -> -500.
//  3 Saturation: OW=16, raw=32767, offset=-32768, gain=2.0 -> m_data=32767; mirrored -> -32768.
//  4 m_ready=0, DEPTH=16 -> 2 frames stored, 3rd dropped, overflow=1, level=16; clr_flags -> 0.
//  5 BUSY held low -> busy_err=1 after 4096 cycles, FSM back to TRIG, next frame proceeds.
//  6 single_shot=1, start pulse mid-READ ignored; enable=0 mid-READ -> frame completes, then IDLE.

Source files
------------

// File: rtl/ad7606_pkg.sv
// AD7606 acquisition controller: shared FSM type, channel limit and
// calibration helpers.
package ad7606_pkg;

    localparam int unsigned MAX_CH = 8;

    typedef enum logic [2:0] {
        ST_ARST,
        ST_IDLE,
        ST_TRIG,
        ST_CONV,
        ST_WAIT_BUSY,
        ST_READ
    } state_t;

    function automatic logic [31:0] unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    // Clamp a wide signed value into the signed range of an ow-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/ad7606_cal_pipe.sv
// Two-stage calibration: offset subtract, then gain multiply with
// arithmetic shift and saturation; channel/last travel alongside.
module ad7606_cal_pipe
    import ad7606_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned OW        = 32,
    parameter int unsigned GAIN_FRAC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [2:0]    in_ch,
    input  logic          in_last,
    input  logic [DW-1:0] raw,
    input  logic [DW-1:0] offset,
    input  logic [31:0]   gain,
    output logic          out_valid,
    output logic [2:0]    out_ch,
    output logic          out_last,
    output logic [OW-1:0] out_data
);

    logic signed [DW:0] s1;
    logic [31:0]        g1;
    logic [2:0]         ch1;
    logic               last1;
    logic               v1;
    logic signed [63:0] scaled;
    logic signed [63:0] sat;

    always_comb begin
        scaled = (64'(s1) * $signed({32'd0, g1})) >>> GAIN_FRAC;
        sat    = saturate(scaled, OW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1        <= '0;
            g1        <= '0;
            ch1       <= '0;
            last1     <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                s1    <= $signed({raw[DW-1], raw}) - $signed({offset[DW-1], offset});
                g1    <= gain;
                ch1   <= in_ch;
                last1 <= in_last;
            end
            if (v1) begin
                out_data <= sat[OW-1:0];
                out_ch   <= ch1;
                out_last <= last1;
            end
        end
    end

endmodule

// File: rtl/ad7606_acq_ctrl.sv
// AD7606 acquisition controller: conversion pacing, BUSY handshake, parallel
// channel read, per-channel calibration and a tagged FWFT output buffer.
module ad7606_acq_ctrl
    import ad7606_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned DW        = 16,
    parameter int unsigned OW        = 32,
    parameter int unsigned GAIN_FRAC = 16,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned RD_LOW    = 2,
    parameter int unsigned RD_HIGH   = 2,
    parameter int unsigned CONV_LOW  = 2,
    parameter int unsigned RST_CYC   = 4,
    parameter int unsigned BUSY_TMO  = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       single_shot,
    input  logic                       start,
    input  logic [15:0]                conv_div,
    input  logic [2:0]                 os_sel,
    input  logic                       busy_i,
    input  logic [DW-1:0]              data_i,
    output logic                       ad_reset_o,
    output logic                       ad_conv_o,
    output logic                       ad_rd_o,
    output logic                       ad_cs_o,
    output logic [2:0]                 ad_os_o,
    input  logic                       cal_wr,
    input  logic [2:0]                 cal_ch,
    input  logic [DW-1:0]              cal_offset,
    input  logic [31:0]                cal_gain,
    output logic [OW-1:0]              m_data,
    output logic [2:0]                 m_ch,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       busy_err,
    input  logic                       clr_flags
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned PH_READ = RD_LOW + RD_HIGH;
    localparam int unsigned EW      = 1 + 3 + OW;

    state_t          state, state_nx;
    logic [15:0]     cnt;
    logic [15:0]     period_cnt;
    logic [15:0]     div;
    logic [2:0]      ch_idx;
    logic            busy_q1, busy_s, busy_seen;
    logic            period_hit, trig_fire, no_room;
    logic            trig_accept, trig_drop, tmo, capture;
    logic [LW-1:0]   level_q, pend;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            wr_en, rd_en;
    logic            pipe_valid, pipe_last;
    logic [2:0]      pipe_ch;
    logic [OW-1:0]   pipe_data;
    logic [EW-1:0]   mem [DEPTH];
    logic [DW-1:0]   cal_off [N_CH];
    logic [31:0]     cal_gn  [N_CH];

    assign div        = (conv_div == 16'd0) ? 16'd1 : conv_div;
    assign period_hit = period_cnt >= div - 16'd1;
    assign trig_fire  = single_shot ? start : period_hit;
    // Pending covers samples of accepted frames not yet written, so a frame
    // is only started when all of its samples are guaranteed a slot.
    assign no_room    = (32'(level_q) + 32'(pend) + N_CH) > DEPTH;

    always_comb begin
        state_nx    = state;
        trig_accept = 1'b0;
        trig_drop   = 1'b0;
        tmo         = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_ARST: if (32'(cnt) == RST_CYC - 1) state_nx = ST_IDLE;
            ST_IDLE: if (enable) state_nx = ST_TRIG;
            ST_TRIG: begin
                if (!enable) state_nx = ST_IDLE;
                else if (trig_fire) begin
                    if (no_room) trig_drop = 1'b1;
                    else begin
                        trig_accept = 1'b1;
                        state_nx    = ST_CONV;
                    end
                end
            end
            ST_CONV: if (32'(cnt) == CONV_LOW - 1) state_nx = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (busy_seen && !busy_s) state_nx = ST_READ;
                else if (32'(cnt) == BUSY_TMO - 1) begin
                    tmo      = 1'b1;
                    state_nx = ST_TRIG;
                end
            end
            ST_READ: begin
                capture = 32'(cnt) == RD_LOW - 1;
                if (32'(cnt) == PH_READ - 1 && 32'(ch_idx) == N_CH - 1)
                    state_nx = enable ? ST_TRIG : ST_IDLE;
            end
            default: state_nx = ST_ARST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ARST;
            cnt        <= '0;
            period_cnt <= '0;
            ch_idx     <= '0;
            busy_q1    <= 1'b0;
            busy_s     <= 1'b0;
            busy_seen  <= 1'b0;
            ad_os_o    <= '0;
            overflow   <= 1'b0;
            busy_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            busy_q1 <= busy_i;
            busy_s  <= busy_q1;
            if (state_nx != state || (state == ST_READ && 32'(cnt) == PH_READ - 1))
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
            if (state == ST_ARST || state == ST_IDLE || period_hit)
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 16'd1;
            if (state != ST_READ)
                ch_idx <= '0;
            else if (32'(cnt) == PH_READ - 1)
                ch_idx <= ch_idx + 3'd1;
            busy_seen <= (state == ST_WAIT_BUSY) && (busy_seen || busy_s);
            if (state == ST_IDLE) ad_os_o <= os_sel;
            overflow <= trig_drop ? 1'b1 : (clr_flags ? 1'b0 : overflow);
            busy_err <= tmo       ? 1'b1 : (clr_flags ? 1'b0 : busy_err);
        end
    end

    assign ad_reset_o = state == ST_ARST;
    assign ad_conv_o  = state != ST_CONV;
    assign ad_cs_o    = state != ST_READ;
    assign ad_rd_o    = !(state == ST_READ && 32'(cnt) < RD_LOW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cal_off[i] <= '0;
                cal_gn[i]  <= unity_gain(GAIN_FRAC);
            end
        end else if (cal_wr && 32'(cal_ch) < N_CH) begin
            cal_off[cal_ch] <= cal_offset;
            cal_gn[cal_ch]  <= cal_gain;
        end
    end

    ad7606_cal_pipe #(
        .DW        (DW),
        .OW        (OW),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_cal (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (capture),
        .in_ch     (ch_idx),
        .in_last   (32'(ch_idx) == N_CH - 1),
        .raw       (data_i),
        .offset    (cal_off[ch_idx]),
        .gain      (cal_gn[ch_idx]),
        .out_valid (pipe_valid),
        .out_ch    (pipe_ch),
        .out_last  (pipe_last),
        .out_data  (pipe_data)
    );

    assign rd_en = m_valid && m_ready;
    assign wr_en = pipe_valid && (level_q != LW'(DEPTH) || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {pipe_last, pipe_ch, pipe_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            pend    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            pend <= pend + (trig_accept ? LW'(N_CH) : LW'(0))
                         - (wr_en       ? LW'(1)    : LW'(0))
                         - (tmo         ? LW'(N_CH) : LW'(0));
        end
    end

    assign {m_last, m_ch, m_data} = mem[rd_ptr];
    assign m_valid = level_q != '0;
    assign level   = level_q;

endmodule

// File: tb/tb_ad7606_acq_ctrl.sv
// Self-checking bench for ad7606_acq_ctrl: behavioural ADC (BUSY + parallel
// data) feeding a scoreboard of calibrated expectations.
module tb_ad7606_acq_ctrl;

    localparam int unsigned OW    = 16;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, enable, single_shot, start;
    logic [15:0] conv_div;
    logic [2:0]  os_sel;
    logic        busy_i;
    logic [15:0] data_i;
    logic        ad_reset_o, ad_conv_o, ad_rd_o, ad_cs_o;
    logic [2:0]  ad_os_o;
    logic        cal_wr;
    logic [2:0]  cal_ch;
    logic [15:0] cal_offset;
    logic [31:0] cal_gain;
    logic [OW-1:0] m_data;
    logic [2:0]  m_ch;
    logic        m_last, m_valid, m_ready;
    logic [$clog2(DEPTH):0] level;
    logic        overflow, busy_err, clr_flags;

    always #5 clk = ~clk;

    ad7606_acq_ctrl #(
        .OW    (OW),
        .DEPTH (DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
        .start(start), .conv_div(conv_div), .os_sel(os_sel), .busy_i(busy_i),
        .data_i(data_i), .ad_reset_o(ad_reset_o), .ad_conv_o(ad_conv_o),
        .ad_rd_o(ad_rd_o), .ad_cs_o(ad_cs_o), .ad_os_o(ad_os_o),
        .cal_wr(cal_wr), .cal_ch(cal_ch), .cal_offset(cal_offset),
        .cal_gain(cal_gain), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .level(level),
        .overflow(overflow), .busy_err(busy_err), .clr_flags(clr_flags)
    );

    typedef struct packed {
        logic        last;
        logic [2:0]  ch;
        logic [15:0] data;
    } beat_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    beat_t       sb[$];
    logic signed [15:0] tb_off  [8];
    logic [31:0]        tb_gain [8];
    logic signed [15:0] raw_tab [8];
    logic [15:0]        last_data [8];
    logic        busy_dead = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_conv = 0;
    int unsigned n_beats = 0;
    int unsigned conv_t[$];
    logic        conv_prev_n = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int ch, input logic signed [15:0] raw);
        longint d;
        longint p;
        d = longint'(raw) - longint'(tb_off[ch]);
        p = (d * longint'({32'd0, tb_gain[ch]})) >>> 16;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic cal_write(input int ch, input logic signed [15:0] off, input logic [31:0] g);
        cal_wr = 1'b1; cal_ch = 3'(ch); cal_offset = off; cal_gain = g;
        tb_off[ch] = off; tb_gain[ch] = g;
        tick(1);
        cal_wr = 1'b0;
    endtask

    task automatic wait_cs_low(input string tag, input int limit);
        int i = 0;
        while (ad_cs_o && i < limit) begin
            tick(1);
            i++;
        end
        check(tag, 64'(ad_cs_o), 64'd0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (conv_prev_n && !ad_conv_o) begin
            n_conv++;
            conv_t.push_back(cyc);
        end
        conv_prev_n = ad_conv_o;
    end

    // ADC read side: drive the next channel's sample on each RD fall and
    // queue the calibrated value the controller must eventually emit.
    initial begin : adc_rd_model
        logic  rd_prev;
        int    rd_cnt;
        beat_t b;
        rd_prev = 1'b1;
        rd_cnt  = 0;
        data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ad_cs_o) rd_cnt = 0;
            else if (rd_prev && !ad_rd_o && rd_cnt < 8) begin
                data_i = raw_tab[rd_cnt];
                b.last = (rd_cnt == 7);
                b.ch   = 3'(rd_cnt);
                b.data = model(rd_cnt, raw_tab[rd_cnt]);
                sb.push_back(b);
                rd_cnt++;
            end
            rd_prev = ad_rd_o;
        end
    end

    initial begin : adc_busy_model
        logic conv_prev;
        conv_prev = 1'b1;
        busy_i    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!conv_prev && ad_conv_o && !busy_dead) begin
                tick(2);
                busy_i = 1'b1;
                tick(40);
                busy_i = 1'b0;
            end
            conv_prev = ad_conv_o;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && m_valid && m_ready) begin
            n_beats++;
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'({m_last, m_ch, m_data}), 64'hDEAD_0000_0000_0000);
            end else begin
                e = sb.pop_front();
                check("m_data", 64'(m_data), 64'(e.data));
                check("m_ch",   64'(m_ch),   64'(e.ch));
                check("m_last", 64'(m_last), 64'(e.last));
            end
            last_data[m_ch] = m_data;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned c0, b0, k, t0;
        rst_n = 1'b0; enable = 1'b1; single_shot = 1'b0; start = 1'b0;
        conv_div = 16'd200; os_sel = 3'd0; m_ready = 1'b1;
        cal_wr = 1'b0; cal_ch = '0; cal_offset = '0; cal_gain = '0; clr_flags = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raw_tab[i]   = 16'(i * 1000 - 3500);
            tb_off[i]    = '0;
            tb_gain[i]   = 32'h0001_0000;
            last_data[i] = '0;
        end
        tick(3);
        check("rst_ad_reset", 64'(ad_reset_o), 64'd1);
        check("rst_ad_conv",  64'(ad_conv_o),  64'd1);
        check("rst_ad_rd",    64'(ad_rd_o),    64'd1);
        check("rst_ad_cs",    64'(ad_cs_o),    64'd1);
        check("rst_ad_os",    64'(ad_os_o),    64'd0);
        check("rst_m_valid",  64'(m_valid),    64'd0);
        check("rst_level",    64'(level),      64'd0);
        check("rst_flags",    64'({overflow, busy_err}), 64'd0);

        // Free-running frames every 200 cycles after a 4-cycle ADC reset
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ad_reset_o) k++;
        end
        check("arst_cycles", 64'(k), 64'd4);
        for (int i = 0; i < 1000 && n_conv < 3; i++) tick(1);
        check("t1_conv_count", 64'(n_conv >= 3), 64'd1);
        if (n_conv >= 3) begin
            check("t1_period_a", 64'(conv_t[1] - conv_t[0]), 64'd200);
            check("t1_period_b", 64'(conv_t[2] - conv_t[1]), 64'd200);
        end
        tick(150);
        check("t1_beats", 64'(n_beats), 64'd24);
        enable = 1'b0;
        tick(300);
        check("t1_drain", 64'(sb.size()), 64'd0);

        // Calibration arithmetic and saturation, single-shot frames
        single_shot = 1'b1; enable = 1'b1;
        tick(2);
        cal_write(3, 16'sd100, 32'h0002_0000);
        cal_write(5, -16'sd32768, 32'h0002_0000);
        cal_write(6, 16'sd32767, 32'h0002_0000);
        raw_tab[3] = 16'sd1100;
        raw_tab[5] = 16'sd32767;
        raw_tab[6] = -16'sd32768;
        pulse_start();
        tick(150);
        check("t2_drain_a", 64'(sb.size()), 64'd0);
        check("t2_gain2",   64'(last_data[3]), 64'(16'd2000));
        check("t3_sat_pos", 64'(last_data[5]), 64'(16'h7FFF));
        check("t3_sat_neg", 64'(last_data[6]), 64'(16'h8000));
        cal_write(3, 16'sd100, 32'h0000_8000);
        raw_tab[3] = -16'sd900;
        pulse_start();
        tick(150);
        check("t2_drain_b", 64'(sb.size()), 64'd0);
        check("t2_gain_half", 64'(last_data[3]), 64'(16'hFE0C));

        // Buffer full: two frames held, third dropped
        enable = 1'b0;
        tick(5);
        m_ready = 1'b0; single_shot = 1'b0;
        c0 = n_conv;
        enable = 1'b1;
        for (int i = 0; i < 1000 && !overflow; i++) tick(1);
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_level",    64'(level),    64'd16);
        check("t4_convs",    64'(n_conv - c0), 64'd2);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("t4_clr", 64'(overflow), 64'd0);
        enable = 1'b0; m_ready = 1'b1;
        tick(100);
        check("t4_level_empty", 64'(level), 64'd0);
        check("t4_drain", 64'(sb.size()), 64'd0);

        // BUSY never asserts: timeout, then recovery
        busy_dead = 1'b1;
        b0 = n_beats;
        enable = 1'b1;
        for (int i = 0; i < 6000 && !busy_err; i++) @(negedge clk);
        t0 = cyc;
        check("t5_busy_err", 64'(busy_err), 64'd1);
        if (conv_t.size() > 0)
            check("t5_tmo_time", 64'(t0 - conv_t[conv_t.size() - 1]), 64'd4098);
        check("t5_no_beats", 64'(n_beats - b0), 64'd0);
        busy_dead = 1'b0;
        tick(1);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("t5_clr", 64'(busy_err), 64'd0);
        tick(400);
        check("t5_recover", 64'(n_beats - b0 >= 8), 64'd1);
        enable = 1'b0;
        tick(300);
        check("t5_drain", 64'(sb.size()), 64'd0);

        // Single-shot: start during READ ignored; enable drop finishes frame
        single_shot = 1'b1;
        os_sel = 3'd3;
        tick(3);
        check("t6_os_idle", 64'(ad_os_o), 64'd3);
        enable = 1'b1;
        tick(3);
        os_sel = 3'd5;
        tick(3);
        check("t6_os_hold", 64'(ad_os_o), 64'd3);
        c0 = n_conv;
        pulse_start();
        wait_cs_low("t6_cs_a", 200);
        pulse_start();
        tick(200);
        check("t6_start_ignored", 64'(n_conv - c0), 64'd1);
        c0 = n_conv; b0 = n_beats;
        pulse_start();
        wait_cs_low("t6_cs_b", 200);
        enable = 1'b0;
        tick(200);
        check("t6_one_frame", 64'(n_conv - c0), 64'd1);
        check("t6_beats", 64'(n_beats - b0), 64'd8);
        check("t6_os_idle2", 64'(ad_os_o), 64'd5);
        check("t6_drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
